// File: rtl/controle_passo_if.sv
// controle_passo_if
// Bundle between the step controller and the processor datapath.
//   endereco_pc     [31:0] current PC reported by the datapath
//   breakpoint      [31:0] halt address (used only when the breakpoint build is enabled)
//   passo                  one-cycle instruction enable
//   parado                 1 while the processor is not free-running
//   contador_passos [15:0] number of passo pulses issued (wraps)
// master: the controller (drives passo/parado/contador_passos)
// slave : the datapath side (drives endereco_pc/breakpoint)
interface controle_passo_if;
  logic [31:0] endereco_pc;
  logic [31:0] breakpoint;
  logic        passo;
  logic        parado;
  logic [15:0] contador_passos;

  modport master (
    input  endereco_pc,
    input  breakpoint,
    output passo,
    output parado,
    output contador_passos
  );

  modport slave (
    output endereco_pc,
    output breakpoint,
    input  passo,
    input  parado,
    input  contador_passos
  );
endinterface

// File: rtl/controle_passo.sv
// controle_passo
// Clock-enable generator feeding pc, banco_registrador and memoria_de_dados.
// Step mode: one passo per debounced press of botao_passo.
// Run mode : one passo every DIV cycles.
// Ports:
//   clock        system clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   botao_passo  raw push-button, active-high, asynchronous
//   chave_modo   raw mode switch (1 = run, 0 = step), asynchronous
//   bus          controle_passo_if.master (endereco_pc, breakpoint in;
//                passo, parado, contador_passos out)
// Parameters:
//   DIV       cycles between enables in run mode (>= 1)
//   DEBOUNCE  cycles a new button level must hold before acceptance (>= 1)
// Build option:
//   CONTROLE_PASSO_BREAKPOINT_EN  adds the PAUSA state and the PC comparator;
//   when undefined, breakpoint is ignored and run mode never halts.
module controle_passo #(
  parameter int unsigned DIV      = 25000000,
  parameter int unsigned DEBOUNCE = 500000
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  botao_passo,
  input  logic                  chave_modo,
  controle_passo_if.master      bus
);

  localparam int unsigned DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned DVW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE - 1);
  localparam logic [DVW-1:0] DIV_LAST = DVW'(DIV - 1);

`ifdef CONTROLE_PASSO_BREAKPOINT_EN
  typedef enum logic [1:0] {
    ESPERA,
    EXECUTA,
    PAUSA
  } estado_t;
`else
  typedef enum logic {
    ESPERA,
    EXECUTA
  } estado_t;

  logic unused_entradas;
  assign unused_entradas = ^{bus.endereco_pc, bus.breakpoint};
`endif

  // Input synchronizers
  logic [1:0] sync_botao;
  logic [1:0] sync_modo;
  logic       botao_s;
  logic       modo_s;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync_botao <= '0;
      sync_modo  <= '0;
    end else begin
      sync_botao <= {sync_botao[0], botao_passo};
      sync_modo  <= {sync_modo[0], chave_modo};
    end
  end

  assign botao_s = sync_botao[1];
  assign modo_s  = sync_modo[1];

  // Button debouncer: a new level is accepted only after DEBOUNCE
  // consecutive synchronized samples that differ from the accepted one.
  logic [DBW-1:0] cnt_debounce;
  logic           estavel;
  logic           estavel_d;
  logic           pressao;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_debounce <= '0;
      estavel      <= 1'b0;
    end else if (botao_s == estavel) begin
      cnt_debounce <= '0;
    end else if (cnt_debounce == DB_LAST) begin
      estavel      <= botao_s;
      cnt_debounce <= '0;
    end else begin
      cnt_debounce <= cnt_debounce + DBW'(1);
    end
  end

  // Rising edge of the accepted level, registered into a one-cycle event
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      estavel_d <= 1'b0;
      pressao   <= 1'b0;
    end else begin
      estavel_d <= estavel;
      pressao   <= estavel & ~estavel_d;
    end
  end

  // Mode FSM with run divider.
  // fim marks a divider terminal count; the enable goes out one edge
  // later, so a breakpoint hit at terminal count can still cancel it.
  estado_t        estado;
  logic [DVW-1:0] divisor;
  logic           fim;
  logic           passo_reg;
  logic           parado_reg;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      estado     <= ESPERA;
      divisor    <= '0;
      fim        <= 1'b0;
      passo_reg  <= 1'b0;
      parado_reg <= 1'b1;
    end else begin
      passo_reg <= 1'b0;
      fim       <= 1'b0;
      case (estado)
        ESPERA: begin
          // A mode change takes priority over a press in the same cycle
          if (modo_s) begin
            estado     <= EXECUTA;
            parado_reg <= 1'b0;
            divisor    <= '0;
          end else begin
            passo_reg <= pressao;
          end
        end

        EXECUTA: begin
          if (!modo_s) begin
            estado     <= ESPERA;
            parado_reg <= 1'b1;
            divisor    <= '0;
          end else begin
            passo_reg <= fim;
            if (divisor == DIV_LAST) begin
              divisor <= '0;
`ifdef CONTROLE_PASSO_BREAKPOINT_EN
              if (bus.endereco_pc == bus.breakpoint) begin
                estado     <= PAUSA;
                parado_reg <= 1'b1;
                passo_reg  <= 1'b0;
              end else begin
                fim <= 1'b1;
              end
`else
              fim <= 1'b1;
`endif
            end else begin
              divisor <= divisor + DVW'(1);
            end
          end
        end

`ifdef CONTROLE_PASSO_BREAKPOINT_EN
        PAUSA: begin
          if (!modo_s) begin
            estado <= ESPERA;
          end
        end
`endif

        default: begin
          estado     <= ESPERA;
          parado_reg <= 1'b1;
          divisor    <= '0;
        end
      endcase
    end
  end

  // Executed-step counter for the display path
  logic [15:0] contador;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      contador <= '0;
    end else if (passo_reg) begin
      contador <= contador + 16'd1;
    end
  end

  assign bus.passo           = passo_reg;
  assign bus.parado          = parado_reg;
  assign bus.contador_passos = contador;

endmodule

// File: doc/controle_passo.md
# controle_passo

Clock-enable generator that sits directly upstream of the processor datapath. It replaces the free-running divided clock with a single-cycle `passo` enable driving `pc`, `banco_registrador` and `memoria_de_dados`. It runs in one of two operator-selected modes:
- step mode: one instruction per debounced push-button press;
- run mode: one instruction every `DIV` cycles.

It also keeps a count of executed steps for the display path.

## Interface
Parameters:
- `DIV`, 25000000, cycles between enables in run mode (≥1)
- `DEBOUNCE`, 500000, cycles the button must hold a new level before it is accepted (≥1)

Ports:
- `clock`  input  1  system clock, all state on rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `botao_passo`  input  1  raw push-button, active-high, asynchronous to `clock`
- `chave_modo`  input  1  raw switch, 1 = run, 0 = step, asynchronous
- `endereco_pc`  input  32  current PC from `pc`
- `breakpoint`  input  32  halt address; ignored unless the macro is defined
- `passo`  output  1  one-cycle instruction enable, registered
- `parado`  output  1  1 when not in run mode, registered
- `contador_passos`  output  16  number of `passo` pulses issued, wraps

## Operation
Input conditioning:
- `botao_passo` and `chave_modo` each pass through a 2-flop synchronizer.
- Button debouncer:
  - `estavel` register plus a counter.
  - The counter clears whenever the synced button equals `estavel`; otherwise it increments.
  - When the counter is at `DEBOUNCE`-1 and the button still differs, `estavel` takes the new level and the counter clears.
  - A registered rising edge of `estavel` produces a one-cycle `pressao` event.
- `chave_modo` is synchronized only, not debounced.

State machine:
- States: ESPERA (step), EXECUTA (run), PAUSA (breakpoint, macro only).
- ESPERA:
  - `pressao` → `passo`=1 next cycle.
  - synced `chave_modo`=1 → EXECUTA, divider cleared.
- EXECUTA:
  - The divider counts 0..`DIV`-1.
  - At `DIV`-1 the divider wraps to 0 and `passo`=1 next cycle.
  - `pressao` is ignored.
  - `chave_modo`=0 → ESPERA, divider cleared.
- PAUSA: no `passo`. `chave_modo`=0 → ESPERA. `pressao` is ignored.
- Simultaneous `pressao` and mode change in the same cycle: the mode change wins and the press is discarded.
- `contador_passos` increments on every cycle in which `passo`=1. 0xFFFF wraps to 0x0000.
- `parado` = 0 only in EXECUTA.

Reset (asynchronous, any cycle, including mid-debounce or mid-divide):
- state ESPERA, `passo`=0, `parado`=1, `contador_passos`=0;
- divider, debounce counter, synchronizers, `estavel` and the edge register all cleared.

No `passo` is emitted in the cycle after reset is released.

## Timing
- `passo` is always exactly one cycle wide and never asserted on two consecutive cycles, except in EXECUTA with `DIV`=1, where it is high every cycle.
- Step latency: with the button held high from the first `clock` edge that samples it high, `passo` is high in the cycle beginning `DEBOUNCE`+3 edges later.
- A button glitch shorter than `DEBOUNCE` cycles after synchronization produces no `passo`.
- Run latency: the first `passo` arrives `DIV`+1 edges after the edge that loads EXECUTA. After that, `passo` repeats every `DIV` cycles.
- Mode latency: a `chave_modo` change is seen by the FSM on the 3rd edge, 2 for the synchronizer plus 1 for the state register.
- A `passo` already registered when leaving EXECUTA is still delivered. No further `passo` is emitted.
- `contador_passos` updates on the edge following the `passo` cycle.

## Configuration
- `CONTROLE_PASSO_BREAKPOINT_EN` defined:
  - In EXECUTA, at divider terminal count, if `endereco_pc` == `breakpoint`, the pending `passo` is suppressed and the state moves to PAUSA. `parado` becomes 1 on the same edge.
  - The breakpoint is checked only in EXECUTA. Step mode can therefore step past it.
- Undefined: the PAUSA state and the comparator are not built, `breakpoint` is unused, and EXECUTA never halts.

## Test plan
Sim parameters: `DEBOUNCE`=4, `DIV`=5.
1. Reset mid-run: drive `rst_n` low asynchronously (between edges) while in EXECUTA with `contador_passos`=3 → `passo`=0, `parado`=1, count 0 immediately. No `passo` for 10 cycles after release with `chave_modo`=0.
2. Step press: `botao_passo` held high for 20 cycles → exactly one `passo`, 7 edges after the first sampled-high edge; count=1. Release and press again → count=2.
3. Bounce rejection: button pulses high 3 cycles, low 2, repeated 5 times → zero `passo`; count stays 0.
4. Run mode: `chave_modo`=1 for 40 cycles → `parado` goes 0 on the 3rd edge. `passo` pulses spaced exactly 5 cycles apart. A button press during the run adds nothing.
5. Mode/press collision: `pressao` and `chave_modo` rising in the same FSM cycle → enters EXECUTA. No step `passo`; the first `passo` arrives after `DIV`+1 edges.
6. Breakpoint (macro on): `breakpoint`=0x0000000C, `endereco_pc` stepped by 4 on each `passo` from 0 → 3 pulses, then `parado`=1 with `endereco_pc`=0x0C and no further `passo`. `chave_modo`=0 → ESPERA. With the macro off, the same stimulus runs without stopping.
